arbitro_rr: RTL and testbench

ARBITRO_RR -- requirements
Module: arbitro_rr

---
 rtl/arbitro_pkg.sv | 26 ++
 rtl/rr_pick.sv | 35 +++
 rtl/arbitro_rr.sv | 130 +++++++++++++
 tb/tb_arbitro_rr.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// arbitro_pkg -- shared definitions for the round-robin arbiter.
//   N_PORTS     : number of input/output FIFO pairs (4)
//   PTR_W       : width of a port index
//   arb_state_t : FSM state encoding (IDLE=00, ACTIVE=01, STALL=10)
//   onehot_to_idx : converts a one-hot port vector to its index
package arbitro_pkg;

  localparam int N_PORTS = 4;
  localparam int PTR_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10
  } arb_state_t;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_PORTS-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin selector.
// Ports:
//   req   [3:0] : request vector (bit i = input i eligible)
//   ptr   [1:0] : search start position
//   grant [3:0] : one-hot grant, first request at or after ptr (mod 4)
//   valid       : at least one request present
module rr_pick
  import arbitro_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant,
  output logic               valid
);

  logic [PTR_W-1:0] sel_idx;
  logic             found;

  // Walk the ports starting at ptr; the 2-bit index wraps naturally.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sel_idx = ptr + PTR_W'(k);
      if (!found && req[sel_idx]) begin
        grant[sel_idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/arbitro_rr.sv
// arbitro_rr -- round-robin arbiter moving words from 4 input FIFOs to
// 4 output FIFOs over a shared bus.
// Ports:
//   clk                      : rising-edge clock
//   reset                    : synchronous, active-low reset
//   empty0..empty3           : input-FIFO empty flags
//   almost_full4..7          : output-FIFO flags (at most one free entry)
//   destino [1:0]            : destination of the word on the shared bus
//   pop0..pop3               : input-FIFO pops (combinational)
//   push4..push7             : output-FIFO pushes (one cycle after the pop)
//   demux [1:0]              : index of the input driving the shared bus
//   state [1:0]              : registered FSM state
//   idle                     : state is IDLE and no word in flight
//   xfer_cnt [CNT_W-1:0]     : push counter, only with ARBITRO_RR_CNT_EN
// Build option: define ARBITRO_RR_CNT_EN to add the xfer_cnt counter/port.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             empty0,
  input  logic             empty1,
  input  logic             empty2,
  input  logic             empty3,
  input  logic             almost_full4,
  input  logic             almost_full5,
  input  logic             almost_full6,
  input  logic             almost_full7,
  input  logic [1:0]       destino,
  output logic             pop0,
  output logic             pop1,
  output logic             pop2,
  output logic             pop3,
  output logic             push4,
  output logic             push5,
  output logic             push6,
  output logic             push7,
  output logic [1:0]       demux,
  output logic [1:0]       state,
  output logic             idle
`ifdef ARBITRO_RR_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] grant;
  logic [N_PORTS-1:0] pop_vec;
  logic [N_PORTS-1:0] push_vec;
  logic               valid;
  logic               stall;
  logic               pop_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   sel_q;
  logic               in_flight;
  arb_state_t         state_q;
  arb_state_t         state_next;

  assign req   = ~{empty3, empty2, empty1, empty0};
  assign stall = |{almost_full7, almost_full6, almost_full5, almost_full4};

  rr_pick u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (valid)
  );

  assign grant_idx = onehot_to_idx(grant);

  // Pops only while out of reset and with room downstream.
  assign pop_any = reset && !stall && valid;
  assign pop_vec = pop_any ? grant : '0;

  // The popped word is pushed next cycle regardless of stall: the
  // almost_full margin reserves the slot it needs. Reset drops it.
  always_comb begin
    push_vec = '0;
    if (reset && in_flight) push_vec[destino] = 1'b1;
  end

  assign demux = reset ? sel_q : '0;

  always_comb begin
    if (!valid)     state_next = IDLE;
    else if (stall) state_next = STALL;
    else            state_next = ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= '0;
      in_flight <= 1'b0;
      sel_q     <= '0;
      state_q   <= IDLE;
    end else begin
      if (pop_any) begin
        rr_ptr    <= grant_idx + PTR_W'(1);
        in_flight <= 1'b1;
        sel_q     <= grant_idx;
      end else begin
        in_flight <= 1'b0;
      end
      state_q <= state_next;
    end
  end

  assign state = state_q;
  assign idle  = (state_q == IDLE) && !in_flight;

  assign {pop3, pop2, pop1, pop0}     = pop_vec;
  assign {push7, push6, push5, push4} = push_vec;

`ifdef ARBITRO_RR_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Free-running transfer count; wraps from all-ones to zero.
  always_ff @(posedge clk) begin
    if (!reset)          cnt <= '0;
    else if (|push_vec)  cnt <= cnt + CNT_W'(1);
  end

  assign xfer_cnt = cnt;
`endif

endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr -- scoreboard bench for arbitro_rr. The stimulus process
// drives inputs, checks pops against a round-robin model and queues the
// expected push; a separate monitor checks pushes, demux, state, idle
// (and xfer_cnt when ARBITRO_RR_CNT_EN is defined).
module tb_arbitro_rr;
  import arbitro_pkg::*;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] empty = 4'hF;
  logic [3:0] af = 4'h0;
  logic [1:0] destino = 2'b00;
  logic [3:0] pop;
  logic [3:0] push;
  logic [1:0] demux;
  logic [1:0] state;
  logic       idle;
`ifdef ARBITRO_RR_CNT_EN
  logic [CNT_W-1:0] xfer_cnt;
`endif

  always #5 clk = ~clk;

  arbitro_rr #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .empty0       (empty[0]),
    .empty1       (empty[1]),
    .empty2       (empty[2]),
    .empty3       (empty[3]),
    .almost_full4 (af[0]),
    .almost_full5 (af[1]),
    .almost_full6 (af[2]),
    .almost_full7 (af[3]),
    .destino      (destino),
    .pop0         (pop[0]),
    .pop1         (pop[1]),
    .pop2         (pop[2]),
    .pop3         (pop[3]),
    .push4        (push[0]),
    .push5        (push[1]),
    .push6        (push[2]),
    .push7        (push[3]),
    .demux        (demux),
    .state        (state),
    .idle         (idle)
`ifdef ARBITRO_RR_CNT_EN
    ,
    .xfer_cnt     (xfer_cnt)
`endif
  );

  typedef struct {
    int src;
    int dst;
    int due;
  } word_t;

  word_t q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cycle = 0;
  int    ptr_m = 0;
  int    cnt_m = 0;
  int    cur_state = 0;
  int    nxt_state = 0;
  bit    mon_en = 1'b0;
  bit    have_m;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock cycle: drive inputs, check pops, advance the model.
  // dst is the destination field carried by a word popped this cycle.
  task automatic step(input bit rst, input logic [3:0] emp, input logic [3:0] a, input int dst);
    int g;
    @(negedge clk);
    cycle++;
    mon_en    = 1'b1;
    cur_state = nxt_state;
    if (!rst) q.delete();
    if (q.size() > 0 && q[0].due == cycle) destino = 2'(q[0].dst);
    else                                   destino = 2'($urandom_range(0, 3));
    reset = rst;
    empty = emp;
    af    = a;
    #1;
    g = -1;
    if (rst && a == 4'h0) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (ptr_m + k) % 4;
        if (g < 0 && !emp[i]) g = i;
      end
    end
    chk("pop", int'(pop), (g < 0) ? 0 : (1 << g));
    $display("cycle %0d rst=%0b empty=%b af=%b pop=%b exp_grant=%0d", cycle, rst, emp, a, pop, g);
    if (g >= 0) begin
      q.push_back('{g, dst, cycle + 1});
      ptr_m = (g + 1) % 4;
    end
    if (!rst) begin
      ptr_m     = 0;
      nxt_state = 0;
    end else if (emp == 4'hF) nxt_state = 0;
    else if (a != 4'h0)      nxt_state = 2;
    else                     nxt_state = 1;
  endtask

  // Monitor: checks the registered side of the arbiter each cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        have_m = (q.size() > 0) && (q[0].due == cycle);
        chk("state", int'(state), cur_state);
        chk("idle", int'(idle), (cur_state == 0 && !have_m) ? 1 : 0);
`ifdef ARBITRO_RR_CNT_EN
        chk("xfer_cnt", int'(xfer_cnt), cnt_m);
`endif
        if (have_m) begin
          chk("push", int'(push), 1 << q[0].dst);
          chk("demux", int'(demux), q[0].src);
          q.pop_front();
          cnt_m = (cnt_m + 1) % (1 << CNT_W);
        end else begin
          chk("push", int'(push), 0);
          if (!reset) chk("demux", int'(demux), 0);
        end
        if (!reset) cnt_m = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles with all inputs non-empty.
    repeat (3) step(1'b0, 4'h0, 4'h0, 0);
    // All inputs eligible: 0,1,2,3,0,1.
    repeat (6) step(1'b1, 4'h0, 4'h0, int'($urandom_range(0, 3)));
    step(1'b1, 4'hF, 4'h0, 0);
    // Only input 2 eligible, destination 3.
    repeat (5) step(1'b1, 4'b1011, 4'h0, 3);
    step(1'b1, 4'hF, 4'h0, 0);
    // Pop to destination 1, then almost_full5 rises in the push cycle.
    step(1'b1, 4'h0, 4'h0, 1);
    repeat (2) step(1'b1, 4'h0, 4'b0010, 0);
    repeat (4) step(1'b1, 4'h0, 4'h0, 2);
    // Reset asserted in the cycle after a pop.
    step(1'b1, 4'h0, 4'h0, 0);
    step(1'b0, 4'h0, 4'h0, 0);
    repeat (2) step(1'b1, 4'h0, 4'h0, 1);
    // 17 transfers after a reset; a 4-bit counter reads 1 afterwards.
    step(1'b0, 4'hF, 4'h0, 0);
    repeat (17) step(1'b1, 4'h0, 4'h0, int'($urandom_range(0, 3)));
    repeat (2) step(1'b1, 4'hF, 4'h0, 0);
    // Randomized traffic.
    repeat (400) begin
      step($urandom_range(0, 39) != 0, 4'($urandom),
           ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0,
           int'($urandom_range(0, 3)));
    end
    repeat (3) step(1'b1, 4'hF, 4'h0, 0);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
